// File: rtl/fifo_burst_reader.sv
// Burst consumer for the read side of a dual-clock FIFO: pops fixed-size bursts and replays them as a valid/ready stream.
// Optional macro FIFO_RD_FLUSH_EN: flush a partial burst after TIMEOUT idle cycles in WAIT.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | FIFO read side in reset, no pops
//   S_WAIT  | waiting for a full burst (or a flush timeout) in the FIFO
//   S_READ  | issuing pops, throttled by output buffer space
//   S_DRAIN | all pops issued, waiting for the last beat to be accepted

module fifo_burst_reader #(
    parameter int DW        = 8,
    parameter int CW        = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic          rd_clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic [CW-1:0] fifo_rd_data_count,
    input  logic          fifo_rd_rst_busy,
    output logic          fifo_rd_en,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          burst_done
);

    localparam int            LW      = $clog2(BURST_LEN + 1);
    localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] len_q, issued, delivered, len_start;
    logic          inflight;
    logic [DW-1:0] buf_mem [3];
    logic [1:0]    wr_ptr, rd_ptr, buf_cnt;
    logic [2:0]    occ;
    logic          beat_acc, last_acc, start_full, start_flush, enter_read;
    logic          burst_done_q;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign occ        = {1'b0, buf_cnt} + {2'b00, inflight};
    assign beat_acc   = m_valid && m_ready;
    assign last_acc   = m_last && m_ready;
    assign start_full = (state == S_WAIT) && (fifo_rd_data_count >= BURST_C);
    assign enter_read = (state == S_WAIT) && (state_nxt == S_READ);

`ifdef FIFO_RD_FLUSH_EN
    localparam int            TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    logic [TW-1:0] idle_left;
    logic          idle_cond;

    assign idle_cond   = (state == S_WAIT) && (fifo_rd_data_count != '0)
                         && (fifo_rd_data_count < BURST_C);
    // Terminal count of 1 means this cycle is the TIMEOUT-th idle cycle.
    assign start_flush = idle_cond && (idle_left == TW'(1));
    assign len_start   = start_full ? BURST_L : LW'(fifo_rd_data_count);

    always_ff @(posedge rd_clk) begin
        if (rst || !idle_cond || (state_nxt != S_WAIT)) idle_left <= TMO;
        else                                             idle_left <= idle_left - 1'b1;
    end
`else
    assign start_flush = 1'b0;
    assign len_start   = BURST_L;
`endif

    always_ff @(posedge rd_clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (fifo_rd_rst_busy) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_WAIT;
                S_WAIT:  if (start_full || start_flush) state_nxt = S_READ;
                S_READ:  if (fifo_rd_en && (issued == len_q - 1'b1)) state_nxt = S_DRAIN;
                S_DRAIN: if (last_acc) state_nxt = S_WAIT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Pop gating uses only registered occupancy, so m_ready never reaches fifo_rd_en.
    always_comb begin
        fifo_rd_en = 1'b0;
        if ((state == S_READ) && !fifo_empty && !fifo_rd_rst_busy
            && (occ < 3'd3) && (issued < len_q))
            fifo_rd_en = 1'b1;
        m_valid    = (buf_cnt != 2'd0);
        m_data     = buf_mem[rd_ptr];
        m_last     = m_valid && (delivered == len_q - 1'b1);
        burst_done = burst_done_q;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight     <= 1'b0;
            wr_ptr       <= 2'd0;
            rd_ptr       <= 2'd0;
            buf_cnt      <= 2'd0;
            issued       <= '0;
            delivered    <= '0;
            len_q        <= '0;
            burst_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
        end else begin
            burst_done_q <= (state == S_DRAIN) && last_acc && !fifo_rd_rst_busy;

            if (fifo_rd_rst_busy) begin
                inflight <= 1'b0;
                wr_ptr   <= 2'd0;
                rd_ptr   <= 2'd0;
                buf_cnt  <= 2'd0;
            end else begin
                inflight <= fifo_rd_en;
                if (inflight) begin
                    buf_mem[wr_ptr] <= fifo_dout;
                    wr_ptr          <= ptr_inc(wr_ptr);
                end
                if (beat_acc) rd_ptr <= ptr_inc(rd_ptr);
                case ({inflight, beat_acc})
                    2'b10:   buf_cnt <= buf_cnt + 2'd1;
                    2'b01:   buf_cnt <= buf_cnt - 2'd1;
                    default: buf_cnt <= buf_cnt;
                endcase
            end

            if (enter_read) begin
                len_q     <= len_start;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (fifo_rd_en) issued    <= issued + 1'b1;
                if (beat_acc)   delivered <= delivered + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model feeding the DUT, scoreboard of pushed words
// checked against accepted output beats, plus reset, threshold, backpressure and rd_rst_busy scenarios.

module tb_fifo_burst_reader;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int BL  = 16;
    localparam int TMO = 255;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_rd_data_count = '0;
    logic          fifo_rd_rst_busy = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          burst_done;

    always #5 rd_clk = ~rd_clk;

    fifo_burst_reader #(.DW(DW), .CW(CW), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .rd_clk             (rd_clk),
        .rst                (rst),
        .fifo_dout          (fifo_dout),
        .fifo_empty         (fifo_empty),
        .fifo_rd_data_count (fifo_rd_data_count),
        .fifo_rd_rst_busy   (fifo_rd_rst_busy),
        .fifo_rd_en         (fifo_rd_en),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_last             (m_last),
        .burst_done         (burst_done)
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    int   n_cmp = 0, n_err = 0;
    logic rst_req = 1'b1, busy_req = 1'b0, rdy_req = 1'b0;
    logic pop_pend = 1'b0, done_exp = 1'b0;
    int   cyc = 0, pops = 0, beats = 0, dones = 0, beat_idx = 0, exp_len = BL;
    int   first_pop = -1, last_pop = -1, first_beat = -1, last_beat = -1;
    logic pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0, pv_rst = 1'b1, pv_busy = 1'b0;
    logic [DW-1:0] pv_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DW'($urandom_range(0, 255));
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic clear_stats();
        pops = 0; beats = 0;
        first_pop = -1; last_pop = -1; first_beat = -1; last_beat = -1;
    endtask

    task automatic sample();
        logic [DW-1:0] e;
        chk("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
        chk("rd_en_while_busy", fifo_rd_en && fifo_rd_rst_busy, 0);
        chk("burst_done", burst_done, done_exp);
        if (burst_done) dones++;
        if (pv_valid && !pv_ready && !pv_rst && !pv_busy) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, pv_data);
            chk("hold_last", m_last, pv_last);
        end
        if (!m_valid) chk("m_last_idle", m_last, 0);
        done_exp = 1'b0;
        if (m_valid && m_ready && !rst && !fifo_rd_rst_busy) begin
            beats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
                chk("sb_has_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", m_data, e);
                chk("m_last", m_last, beat_idx == exp_len - 1);
                if (beat_idx == exp_len - 1) begin
                    beat_idx = 0;
                    done_exp = 1'b1;
                end else begin
                    beat_idx++;
                end
            end
        end
        if (fifo_rd_en) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        pop_pend = fifo_rd_en;
        pv_valid = m_valid; pv_ready = m_ready; pv_data = m_data; pv_last = m_last;
        pv_rst = rst; pv_busy = fifo_rd_rst_busy;
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge rd_clk);
        #1;
        if (pop_pend && fq.size() > 0) fifo_dout = fq.pop_front();
        rst                = rst_req;
        fifo_rd_rst_busy   = busy_req;
        m_ready            = rdy_req;
        fifo_rd_data_count = CW'(fq.size());
        fifo_empty         = (fq.size() == 0);
        cyc++;
        @(negedge rd_clk);
        sample();
    endtask

    task automatic run_until_done(input int budget, input int mode, input int n);
        int d0;
        d0 = dones;
        for (int i = 0; i < budget && (dones - d0) < n; i++) begin
            case (mode)
                0:       rdy_req = 1'b1;
                1:       rdy_req = ~rdy_req;
                default: rdy_req = 1'($urandom_range(0, 1));
            endcase
            cycle();
        end
        rdy_req = 1'b1;
        repeat (4) cycle();
        chk("burst_done_count", dones - d0, n);
    endtask

    initial begin
        int c_s;

        // Reset held with a full FIFO behind it.
        rst_req = 1'b1;
        rdy_req = 1'b1;
        push_words(20);
        repeat (3) begin
            cycle();
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_burst_done", burst_done, 0);
            chk("rst_m_data", m_data, 0);
        end
        rst_req = 1'b0;
        cycle(); chk("rel_rd_en_0", fifo_rd_en, 0);
        cycle(); chk("rel_rd_en_1", fifo_rd_en, 0);
        cycle(); chk("rel_rd_en_2", fifo_rd_en, 1);
        run_until_done(100, 0, 1);

        // Full rate: 4 left over + 12 new makes exactly one burst.
        clear_stats();
        push_words(12);
        run_until_done(100, 0, 1);
        chk("full_pops", pops, 16);
        chk("full_pop_span", last_pop - first_pop, 15);
        chk("full_beats", beats, 16);
        chk("full_beat_span", last_beat - first_beat, 15);

        // Backpressure: alternating and random ready.
        clear_stats();
        push_words(16);
        run_until_done(300, 1, 1);
        chk("bp_beats", beats, 16);
        clear_stats();
        push_words(32);
        run_until_done(600, 2, 2);
        chk("rand_beats", beats, 32);

`ifndef FIFO_RD_FLUSH_EN
        clear_stats();
        push_words(15);
        rdy_req = 1'b1;
        repeat (1000) cycle();
        chk("thr_no_pop", pops, 0);
        push_words(1);
        run_until_done(100, 0, 1);
        chk("thr_pops", pops, 16);
`else
        clear_stats();
        exp_len = 5;
        push_words(5);
        rdy_req = 1'b1;
        cycle();
        c_s = cyc;
        for (int i = 0; i < 400 && pops == 0; i++) cycle();
        chk("flush_delay", first_pop - c_s, TMO);
        run_until_done(100, 0, 1);
        chk("flush_beats", beats, 5);
        exp_len = BL;
`endif

        // rd_rst_busy after 7 pops: everything in flight is dropped.
        clear_stats();
        push_words(16);
        rdy_req = 1'b1;
        for (int i = 0; i < 100 && pops < 7; i++) cycle();
        chk("busy_pre_pops", pops, 7);
        busy_req = 1'b1;
        fq.delete();
        exp_q.delete();
        beat_idx = 0;
        cycle();
        repeat (10) begin
            cycle();
            chk("busy_m_valid", m_valid, 0);
            chk("busy_rd_en", fifo_rd_en, 0);
        end
        chk("busy_no_pop", pops, 7);
        busy_req = 1'b0;
        clear_stats();
        push_words(16);
        run_until_done(100, 0, 1);
        chk("busy_post_pops", pops, 16);

        // Synchronous reset mid-burst.
        clear_stats();
        push_words(16);
        for (int i = 0; i < 100 && pops < 5; i++) cycle();
        rst_req = 1'b1;
        fq.delete();
        exp_q.delete();
        beat_idx = 0;
        cycle();
        cycle();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_rd_en", fifo_rd_en, 0);
        rst_req = 1'b0;
        clear_stats();
        push_words(16);
        run_until_done(100, 0, 1);
        chk("midrst_post_beats", beats, 16);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
